// File: rtl/wb_pkg.sv
// Shared types and sizing for the writeback stage and integer register file.
// Also holds the writeback source priority encoder.
package wb_pkg;

   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int REG_AW = $clog2(NREGS);
   localparam int CNT_W  = 64;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_MEM,
      WB_IMM,
      WB_PC4
   } wb_sel_e;

   // Link address beats immediate, which beats load data; ALU is the fallback.
   function automatic wb_sel_e wb_select(
      input logic jump,
      input logic uilu,
      input logic mem_to_reg
   );
      wb_sel_e sel;
      if (jump)
         sel = WB_PC4;
      else if (uilu)
         sel = WB_IMM;
      else if (mem_to_reg)
         sel = WB_MEM;
      else
         sel = WB_ALU;
      return sel;
   endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read one-write integer register file, x0 hardwired to zero,
// with a same-cycle write-to-read bypass and asynchronous clear.
module regfile_2r1w
   import wb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [XLEN-1:0]   wdata,
   input  logic [REG_AW-1:0] raddr1,
   input  logic [REG_AW-1:0] raddr2,
   output logic [XLEN-1:0]   rdata1,
   output logic [XLEN-1:0]   rdata2
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_ok;

   assign wr_ok = we && (waddr != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[waddr] <= wdata;
      end
   end

   // Reset masks the bypass too, so every address reads zero while held.
   always_comb begin
      rdata1 = '0;
      if (reset || raddr1 == '0)
         rdata1 = '0;
      else if (wr_ok && waddr == raddr1)
         rdata1 = wdata;
      else
         rdata1 = regs[raddr1];
   end

   always_comb begin
      rdata2 = '0;
      if (reset || raddr2 == '0)
         rdata2 = '0;
      else if (wr_ok && waddr == raddr2)
         rdata2 = wdata;
      else
         rdata2 = regs[raddr2];
   end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: source select, register file write/read with bypass,
// and the retired-instruction counter consumed by the CSR unit.
module wb_regfile
   import wb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [XLEN-1:0]   alu_result_in,
   input  logic [XLEN-1:0]   read_data_in,
   input  logic [XLEN-1:0]   imm_in,
   input  logic [XLEN-1:0]   pc_plus_4_in,
   input  logic              reg_write_in,
   input  logic              mem_to_reg_in,
   input  logic              jump_in,
   input  logic              uilu_in,
   input  logic [REG_AW-1:0] write_reg_in,
   input  logic              retire_in,
   input  logic [REG_AW-1:0] rs1_addr,
   input  logic [REG_AW-1:0] rs2_addr,
   output logic [XLEN-1:0]   rs1_data,
   output logic [XLEN-1:0]   rs2_data,
   output logic [XLEN-1:0]   wb_data,
   output logic              wb_we,
   output logic [CNT_W-1:0]  instret
);

   wb_sel_e          sel;
   logic [CNT_W-1:0] instret_q;

   always_comb begin
      sel = wb_select(jump_in, uilu_in, mem_to_reg_in);
   end

   always_comb begin
      wb_data = alu_result_in;
      unique case (sel)
         WB_PC4:  wb_data = pc_plus_4_in;
         WB_IMM:  wb_data = imm_in;
         WB_MEM:  wb_data = read_data_in;
         WB_ALU:  wb_data = alu_result_in;
         default: wb_data = alu_result_in;
      endcase
   end

   // An X destination with write disabled still resolves to no write.
   assign wb_we = reg_write_in && (write_reg_in != '0);

   regfile_2r1w u_rf (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_we),
      .waddr  (write_reg_in),
      .wdata  (wb_data),
      .raddr1 (rs1_addr),
      .raddr2 (rs2_addr),
      .rdata1 (rs1_data),
      .rdata2 (rs2_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         instret_q <= '0;
      else if (retire_in)
         instret_q <= instret_q + CNT_W'(1);
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/bypass, x0, select priority,
// instret counting and wrap, and reset arriving mid-stream.
module tb_wb_regfile;

   logic        clk;
   logic        reset;
   logic [31:0] alu_result_in;
   logic [31:0] read_data_in;
   logic [31:0] imm_in;
   logic [31:0] pc_plus_4_in;
   logic        reg_write_in;
   logic        mem_to_reg_in;
   logic        jump_in;
   logic        uilu_in;
   logic [4:0]  write_reg_in;
   logic        retire_in;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] wb_data;
   logic        wb_we;
   logic [63:0] instret;

   int n_cmp;
   int n_err;

   wb_regfile dut (
      .clk           (clk),
      .reset         (reset),
      .alu_result_in (alu_result_in),
      .read_data_in  (read_data_in),
      .imm_in        (imm_in),
      .pc_plus_4_in  (pc_plus_4_in),
      .reg_write_in  (reg_write_in),
      .mem_to_reg_in (mem_to_reg_in),
      .jump_in       (jump_in),
      .uilu_in       (uilu_in),
      .write_reg_in  (write_reg_in),
      .retire_in     (retire_in),
      .rs1_addr      (rs1_addr),
      .rs2_addr      (rs2_addr),
      .rs1_data      (rs1_data),
      .rs2_data      (rs2_data),
      .wb_data       (wb_data),
      .wb_we         (wb_we),
      .instret       (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reg_write_in  = 1'b0;
      mem_to_reg_in = 1'b0;
      jump_in       = 1'b0;
      uilu_in       = 1'b0;
      write_reg_in  = 5'd0;
      retire_in     = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset         = 1'b1;
      reg_write_in  = 1'b1;
      write_reg_in  = 5'd5;
      alu_result_in = 32'hCAFE_F00D;
      step();
      step();
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(a);
         #1;
         n_cmp++;
         if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_read a=%0d got %h/%h want 0", a, rs1_data, rs2_data);
         end
      end
      n_cmp++;
      if (instret !== 64'd0) begin
         n_err++;
         $display("FAIL reset_instret got %0d want 0", instret);
      end
      n_cmp++;
      if (wb_we !== 1'b1 || wb_data !== 32'hCAFE_F00D) begin
         n_err++;
         $display("FAIL reset_wb got we=%b d=%h want 1/cafef00d", wb_we, wb_data);
      end
      idle();
      #1;
      reset = 1'b0;
      rs1_addr = 5'd5;
      rs2_addr = 5'd31;
      #1;
      n_cmp++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0 || instret !== 64'd0) begin
         n_err++;
         $display("FAIL reset_release got %h/%h/%0d want 0/0/0", rs1_data, rs2_data, instret);
      end
   endtask

   task automatic test_write_bypass();
      idle();
      reg_write_in  = 1'b1;
      write_reg_in  = 5'd5;
      alu_result_in = 32'hDEAD_BEEF;
      rs1_addr      = 5'd6;
      rs2_addr      = 5'd5;
      #1;
      n_cmp++;
      if (rs2_data !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL bypass got %h want deadbeef", rs2_data);
      end
      n_cmp++;
      if (rs1_data !== 32'd0) begin
         n_err++;
         $display("FAIL no_bypass_x6 got %h want 0", rs1_data);
      end
      step();
      idle();
      alu_result_in = 32'h0;
      rs1_addr      = 5'd5;
      #1;
      n_cmp++;
      if (rs1_data !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL write_x5 got %h want deadbeef", rs1_data);
      end
   endtask

   task automatic test_x0();
      idle();
      reg_write_in  = 1'b1;
      write_reg_in  = 5'd0;
      alu_result_in = 32'h0000_1234;
      rs1_addr      = 5'd0;
      #1;
      n_cmp++;
      if (wb_we !== 1'b0 || rs1_data !== 32'd0) begin
         n_err++;
         $display("FAIL x0_same got we=%b d=%h want 0/0", wb_we, rs1_data);
      end
      step();
      idle();
      #1;
      n_cmp++;
      if (rs1_data !== 32'd0) begin
         n_err++;
         $display("FAIL x0_after got %h want 0", rs1_data);
      end
      write_reg_in  = 5'bxxxxx;
      alu_result_in = 32'hFFFF_FFFF;
      rs1_addr      = 5'd5;
      #1;
      n_cmp++;
      if (wb_we !== 1'b0) begin
         n_err++;
         $display("FAIL x_dest_we got %b want 0", wb_we);
      end
      step();
      write_reg_in = 5'd0;
      #1;
      n_cmp++;
      if (rs1_data !== 32'hDEAD_BEEF) begin
         n_err++;
         $display("FAIL x_dest_state got %h want deadbeef", rs1_data);
      end
   endtask

   task automatic test_priority();
      idle();
      alu_result_in = 32'd1;
      read_data_in  = 32'd2;
      imm_in        = 32'd3;
      pc_plus_4_in  = 32'd4;
      jump_in       = 1'b1;
      uilu_in       = 1'b1;
      mem_to_reg_in = 1'b1;
      #1;
      n_cmp++;
      if (wb_data !== 32'd4) begin
         n_err++;
         $display("FAIL sel_all got %0d want 4", wb_data);
      end
      jump_in = 1'b0;
      #1;
      n_cmp++;
      if (wb_data !== 32'd3) begin
         n_err++;
         $display("FAIL sel_uilu_mem got %0d want 3", wb_data);
      end
      uilu_in = 1'b0;
      #1;
      n_cmp++;
      if (wb_data !== 32'd2) begin
         n_err++;
         $display("FAIL sel_mem got %0d want 2", wb_data);
      end
      mem_to_reg_in = 1'b0;
      #1;
      n_cmp++;
      if (wb_data !== 32'd1) begin
         n_err++;
         $display("FAIL sel_alu got %0d want 1", wb_data);
      end
      jump_in = 1'b1;
      #1;
      n_cmp++;
      if (wb_data !== 32'd4) begin
         n_err++;
         $display("FAIL sel_jump got %0d want 4", wb_data);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      idle();
      reg_write_in  = 1'b1;
      write_reg_in  = 5'd1;
      alu_result_in = 32'd11;
      step();
      write_reg_in  = 5'd2;
      alu_result_in = 32'd22;
      rs1_addr      = 5'd1;
      rs2_addr      = 5'd2;
      #1;
      n_cmp++;
      if (rs1_data !== 32'd11 || rs2_data !== 32'd22) begin
         n_err++;
         $display("FAIL b2b got %0d/%0d want 11/22", rs1_data, rs2_data);
      end
      step();
      alu_result_in = 32'd33;
      rs1_addr      = 5'd2;
      #1;
      n_cmp++;
      if (rs1_data !== 32'd33 || rs2_data !== 32'd33) begin
         n_err++;
         $display("FAIL same_reg_bypass got %0d/%0d want 33/33", rs1_data, rs2_data);
      end
      step();
      idle();
      rs1_addr = 5'd1;
      #1;
      n_cmp++;
      if (rs1_data !== 32'd11 || rs2_data !== 32'd33) begin
         n_err++;
         $display("FAIL b2b_state got %0d/%0d want 11/33", rs1_data, rs2_data);
      end
   endtask

   task automatic test_instret();
      idle();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      for (int i = 0; i < 11; i++) begin
         retire_in = (i != 4);
         step();
      end
      retire_in = 1'b0;
      n_cmp++;
      if (instret !== 64'd10) begin
         n_err++;
         $display("FAIL instret_count got %0d want 10", instret);
      end
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      #1;
      n_cmp++;
      if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         n_err++;
         $display("FAIL instret_preload got %h want ffffffffffffffff", instret);
      end
      retire_in = 1'b1;
      step();
      step();
      retire_in = 1'b0;
      n_cmp++;
      if (instret !== 64'd1) begin
         n_err++;
         $display("FAIL instret_wrap got %0d want 1", instret);
      end
      reg_write_in = 1'b1;
      write_reg_in = 5'd9;
      step();
      idle();
      n_cmp++;
      if (instret !== 64'd1) begin
         n_err++;
         $display("FAIL instret_no_retire got %0d want 1", instret);
      end
   endtask

   task automatic test_reset_midstream();
      idle();
      reg_write_in  = 1'b1;
      write_reg_in  = 5'd7;
      alu_result_in = 32'h0000_AAAA;
      retire_in     = 1'b1;
      step();
      step();
      rs1_addr      = 5'd7;
      alu_result_in = 32'h0000_5555;
      #1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (rs1_data !== 32'd0 || instret !== 64'd0) begin
         n_err++;
         $display("FAIL mid_reset got %h/%0d want 0/0", rs1_data, instret);
      end
      step();
      idle();
      reset = 1'b0;
      #1;
      n_cmp++;
      if (rs1_data !== 32'd0 || instret !== 64'd0) begin
         n_err++;
         $display("FAIL mid_reset_lost got %h/%0d want 0/0", rs1_data, instret);
      end
      reg_write_in  = 1'b1;
      write_reg_in  = 5'd7;
      alu_result_in = 32'h0000_0077;
      step();
      idle();
      #1;
      n_cmp++;
      if (rs1_data !== 32'h0000_0077) begin
         n_err++;
         $display("FAIL post_reset_write got %h want 77", rs1_data);
      end
   endtask

   initial begin
      n_cmp         = 0;
      n_err         = 0;
      reset         = 1'b1;
      alu_result_in = '0;
      read_data_in  = '0;
      imm_in        = '0;
      pc_plus_4_in  = '0;
      rs1_addr      = '0;
      rs2_addr      = '0;
      idle();
      test_reset();
      test_write_bypass();
      test_x0();
      test_priority();
      test_back_to_back();
      test_instret();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
